// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified-memory arbiter.
// Read responses are routed by an owner tag that travels alongside the memory read latency.
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF     = 32;
  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned READ_LAT_DEF   = 1;
  localparam int unsigned STARVE_MAX_DEF = 8;
  localparam int unsigned MASK_W         = 4;
  localparam int unsigned STARVE_CNT_W   = 8;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_DBG  = 1'b1
  } owner_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
  } rd_tag_t;

  function automatic logic tag_hits(rd_tag_t tag, owner_t owner);
    return tag.valid && (tag.owner == owner);
  endfunction

endpackage

// File: rtl/rd_tag_pipe.sv
// Fixed-depth shift register of read owner tags, aligned with the memory read latency.
// Tags reset to invalid so reads in flight at reset never produce a response.
module rd_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int unsigned Depth = 1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  rd_tag_t i_tag,
  output rd_tag_t o_tag
);

  rd_tag_t r_stage [Depth];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= i_tag;
      for (int i = 1; i < Depth; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_tag = r_stage[Depth-1];

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter for the single instruction/data memory: core vs debug/loader.
// Grants are combinational; read data returns to whichever port owned the access.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned READ_LAT   = READ_LAT_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  input  logic [MASK_W-1:0] core_wmask,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic [MASK_W-1:0] dbg_wmask,
  input  logic              dbg_lock,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [MASK_W-1:0] mem_wmask,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              core_stall
);

  logic [STARVE_CNT_W-1:0] r_starve_cnt;
  logic [DATA_W-1:0]       r_core_rdata;
  logic [DATA_W-1:0]       r_dbg_rdata;
  logic                    w_starved;
  logic                    w_core_gnt;
  logic                    w_dbg_gnt;
  logic [ADDR_W-1:0]       w_addr;
  logic                    w_unused_addr_lsb;
  rd_tag_t                 w_tag_in;
  rd_tag_t                 w_tag_out;

  assign w_starved = (r_starve_cnt == STARVE_CNT_W'(STARVE_MAX));

  // Everything combinational is gated by rst_n so the outputs read idle while in reset.
  always_comb begin
    w_core_gnt = 1'b0;
    w_dbg_gnt  = 1'b0;
    if (rst_n) begin
      if (dbg_lock) begin
        w_dbg_gnt = dbg_req;
      end else if (dbg_req && (w_starved || !core_req)) begin
        w_dbg_gnt = 1'b1;
      end else begin
        w_core_gnt = core_req;
      end
    end
  end

  always_comb begin
    w_addr    = '0;
    mem_we    = 1'b0;
    mem_wmask = '0;
    mem_wdata = '0;
    if (w_core_gnt) begin
      w_addr    = core_addr;
      mem_we    = core_we;
      mem_wmask = core_we ? core_wmask : '0;
      mem_wdata = core_wdata;
    end else if (w_dbg_gnt) begin
      w_addr    = dbg_addr;
      mem_we    = dbg_we;
      mem_wmask = dbg_we ? dbg_wmask : '0;
      mem_wdata = dbg_wdata;
    end
  end

  assign mem_addr          = {w_addr[ADDR_W-1:2], 2'b00};
  assign w_unused_addr_lsb = ^w_addr[1:0];

  assign core_gnt   = w_core_gnt;
  assign dbg_gnt    = w_dbg_gnt;
  assign core_stall = rst_n & (dbg_lock | (core_req & ~w_core_gnt));

  always_comb begin
    w_tag_in.valid = (w_core_gnt & ~core_we) | (w_dbg_gnt & ~dbg_we);
    w_tag_in.owner = w_dbg_gnt ? OWN_DBG : OWN_CORE;
  end

  rd_tag_pipe #(
    .Depth (READ_LAT)
  ) u_rd_tag_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .i_tag (w_tag_in),
    .o_tag (w_tag_out)
  );

  assign core_rvalid = tag_hits(w_tag_out, OWN_CORE);
  assign dbg_rvalid  = tag_hits(w_tag_out, OWN_DBG);

  // Returning data is forwarded in the response cycle, then held for the idle cycles after.
  assign core_rdata = core_rvalid ? mem_rdata : r_core_rdata;
  assign dbg_rdata  = dbg_rvalid  ? mem_rdata : r_dbg_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
      r_core_rdata <= '0;
      r_dbg_rdata  <= '0;
    end else begin
      if (!dbg_req || w_dbg_gnt) begin
        r_starve_cnt <= '0;
      end else if (!w_starved) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end
      if (core_rvalid) begin
        r_core_rdata <= mem_rdata;
      end
      if (dbg_rvalid) begin
        r_dbg_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: two arbiters (read latency 1 and 3) share one stimulus stream and a
// word-addressed memory model with hand-known contents.
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        core_req, core_we, dbg_req, dbg_we, dbg_lock;
  logic [31:0] core_addr, core_wdata, dbg_addr, dbg_wdata;
  logic [3:0]  core_wmask, dbg_wmask;

  logic        core_gnt_1, core_rvalid_1, dbg_gnt_1, dbg_rvalid_1, mem_we_1, core_stall_1;
  logic [31:0] core_rdata_1, dbg_rdata_1, mem_addr_1, mem_wdata_1, mem_rdata_1;
  logic [3:0]  mem_wmask_1;
  logic        core_gnt_3, core_rvalid_3, dbg_gnt_3, dbg_rvalid_3, mem_we_3, core_stall_3;
  logic [31:0] core_rdata_3, dbg_rdata_3, mem_addr_3, mem_wdata_3, mem_rdata_3;
  logic [3:0]  mem_wmask_3;

  int n_cmp;
  int n_err;

  logic [31:0] mem [256];
  logic [31:0] rd1_q;
  logic [31:0] rd3_q [3];
  bit          preloaded;

  mem_arbiter #(.READ_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_wmask(core_wmask),
    .core_gnt(core_gnt_1), .core_rvalid(core_rvalid_1), .core_rdata(core_rdata_1),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_wmask(dbg_wmask), .dbg_lock(dbg_lock),
    .dbg_gnt(dbg_gnt_1), .dbg_rvalid(dbg_rvalid_1), .dbg_rdata(dbg_rdata_1),
    .mem_addr(mem_addr_1), .mem_we(mem_we_1), .mem_wmask(mem_wmask_1),
    .mem_wdata(mem_wdata_1), .mem_rdata(mem_rdata_1), .core_stall(core_stall_1)
  );

  mem_arbiter #(.READ_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_wmask(core_wmask),
    .core_gnt(core_gnt_3), .core_rvalid(core_rvalid_3), .core_rdata(core_rdata_3),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_wmask(dbg_wmask), .dbg_lock(dbg_lock),
    .dbg_gnt(dbg_gnt_3), .dbg_rvalid(dbg_rvalid_3), .dbg_rdata(dbg_rdata_3),
    .mem_addr(mem_addr_3), .mem_we(mem_we_3), .mem_wmask(mem_wmask_3),
    .mem_wdata(mem_wdata_3), .mem_rdata(mem_rdata_3), .core_stall(core_stall_3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word i holds 0xC0DE0000 | byte address, except word 4 (0x10) which holds 0xDEADBEEF.
  always @(posedge clk) begin
    if (!preloaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hC0DE_0000 | 32'(i * 4);
      mem[4]    <= 32'hDEAD_BEEF;
      preloaded <= 1'b1;
    end else if (mem_we_1) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_wmask_1[b]) mem[mem_addr_1[9:2]][8*b +: 8] <= mem_wdata_1[8*b +: 8];
      end
    end
    rd1_q    <= mem[mem_addr_1[9:2]];
    rd3_q[0] <= mem[mem_addr_3[9:2]];
    rd3_q[1] <= rd3_q[0];
    rd3_q[2] <= rd3_q[1];
  end

  assign mem_rdata_1 = rd1_q;
  assign mem_rdata_3 = rd3_q[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0; core_wmask = '0;
    dbg_req  = 1'b0; dbg_we  = 1'b0; dbg_addr  = '0; dbg_wdata  = '0; dbg_wmask  = '0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    idle();
    rst_n    = 1'b0;
    dbg_lock = 1'b1;
    core_req = 1'b1;
    dbg_req  = 1'b1;
    cyc();
    cyc();
    settle();
    chk("rst_core_gnt", core_gnt_1, 0);
    chk("rst_dbg_gnt", dbg_gnt_1, 0);
    chk("rst_mem_we", mem_we_1, 0);
    chk("rst_mem_addr", mem_addr_1, 0);
    chk("rst_core_stall", core_stall_1, 0);
    chk("rst_core_rvalid", core_rvalid_1, 0);
    chk("rst_dbg_rvalid", dbg_rvalid_1, 0);
    chk("rst_core_rdata", core_rdata_1, 0);
    idle();
    dbg_lock = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();

    // Core-only read of 0x10.
    core_req = 1'b1; core_addr = 32'h10;
    settle();
    chk("t1_core_gnt", core_gnt_1, 1);
    chk("t1_dbg_gnt", dbg_gnt_1, 0);
    chk("t1_mem_addr", mem_addr_1, 32'h10);
    chk("t1_core_stall", core_stall_1, 0);
    cyc(); idle(); settle();
    chk("t1_core_rvalid", core_rvalid_1, 1);
    chk("t1_core_rdata", core_rdata_1, 32'hDEAD_BEEF);
    chk("t1_dbg_rvalid", dbg_rvalid_1, 0);
    cyc(); settle();
    chk("t1_rvalid_pulse", core_rvalid_1, 0);
    chk("t1_rdata_hold", core_rdata_1, 32'hDEAD_BEEF);
    cyc(); cyc(); cyc();

    // Conflict: core wins for 8 cycles, dbg forced on the 9th.
    core_req = 1'b1; core_addr = 32'h20;
    dbg_req  = 1'b1; dbg_addr  = 32'h40;
    settle();
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t2_core_gnt_c%0d", k), core_gnt_1, 1);
      chk($sformatf("t2_dbg_gnt_c%0d", k), dbg_gnt_1, 0);
      chk($sformatf("t2_stall_c%0d", k), core_stall_1, 0);
      cyc(); settle();
    end
    chk("t2_dbg_forced", dbg_gnt_1, 1);
    chk("t2_core_lost", core_gnt_1, 0);
    chk("t2_core_stall", core_stall_1, 1);
    chk("t2_mem_addr", mem_addr_1, 32'h40);
    cyc(); idle(); settle();
    chk("t2_dbg_rvalid", dbg_rvalid_1, 1);
    chk("t2_dbg_rdata", dbg_rdata_1, 32'hC0DE_0040);
    chk("t2_core_rvalid", core_rvalid_1, 0);
    chk("t2_core_rdata_hold", core_rdata_1, 32'hC0DE_0020);
    chk("t2_idle_mem_we", mem_we_1, 0);
    cyc(); cyc(); cyc();

    // Loader lock: dbg write while core is shut out.
    dbg_lock = 1'b1;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h100;
    dbg_wdata = 32'h1234_5678; dbg_wmask = 4'hF;
    core_req = 1'b1; core_addr = 32'h100;
    settle();
    chk("t3_mem_we", mem_we_1, 1);
    chk("t3_mem_addr", mem_addr_1, 32'h100);
    chk("t3_mem_wdata", mem_wdata_1, 32'h1234_5678);
    chk("t3_mem_wmask", mem_wmask_1, 4'hF);
    chk("t3_dbg_gnt", dbg_gnt_1, 1);
    chk("t3_core_gnt", core_gnt_1, 0);
    chk("t3_core_stall", core_stall_1, 1);
    cyc();
    dbg_req = 1'b0; dbg_we = 1'b0;
    settle();
    chk("t3_locked_core_gnt", core_gnt_1, 0);
    chk("t3_locked_stall", core_stall_1, 1);
    chk("t3_locked_mem_we", mem_we_1, 0);
    cyc();
    dbg_lock = 1'b0;
    settle();
    chk("t3_unlock_core_gnt", core_gnt_1, 1);
    chk("t3_unlock_stall", core_stall_1, 0);
    cyc(); idle(); settle();
    chk("t3_readback_valid", core_rvalid_1, 1);
    chk("t3_readback_data", core_rdata_1, 32'h1234_5678);
    cyc(); cyc(); cyc();

    // Byte write to an unaligned address.
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h203;
    dbg_wdata = 32'h00AB_0000; dbg_wmask = 4'b0100;
    settle();
    chk("t6_mem_addr", mem_addr_1, 32'h200);
    chk("t6_mem_wmask", mem_wmask_1, 4'b0100);
    chk("t6_mem_we", mem_we_1, 1);
    chk("t6_mem_wdata", mem_wdata_1, 32'h00AB_0000);
    chk("t6_l3_mem_we", mem_we_3, 1);
    chk("t6_l3_mem_wmask", mem_wmask_3, 4'b0100);
    chk("t6_l3_mem_wdata", mem_wdata_3, 32'h00AB_0000);
    cyc(); idle();
    core_req = 1'b1; core_addr = 32'h200;
    settle();
    chk("t6_we_one_cycle", mem_we_1, 0);
    chk("t6_core_gnt", core_gnt_1, 1);
    cyc(); idle(); settle();
    chk("t6_merged_word", core_rdata_1, 32'hC0AB_0200);
    cyc(); cyc(); cyc();

    // READ_LAT=3: alternating core/dbg reads, responses in order.
    core_req = 1'b1; core_addr = 32'h30;
    settle();
    chk("t4_c0_core_gnt", core_gnt_3, 1);
    chk("t4_c0_core_rvalid", core_rvalid_3, 0);
    chk("t4_c0_dbg_rvalid", dbg_rvalid_3, 0);
    cyc(); idle(); dbg_req = 1'b1; dbg_addr = 32'h50;
    settle();
    chk("t4_c1_dbg_gnt", dbg_gnt_3, 1);
    chk("t4_c1_l1_core_rvalid", core_rvalid_1, 1);
    chk("t4_c1_l1_core_rdata", core_rdata_1, 32'hC0DE_0030);
    chk("t4_c1_core_rvalid", core_rvalid_3, 0);
    cyc(); idle(); core_req = 1'b1; core_addr = 32'h60;
    settle();
    chk("t4_c2_core_rvalid", core_rvalid_3, 0);
    chk("t4_c2_dbg_rvalid", dbg_rvalid_3, 0);
    cyc(); idle(); dbg_req = 1'b1; dbg_addr = 32'h70;
    settle();
    chk("t4_c3_core_rvalid", core_rvalid_3, 1);
    chk("t4_c3_core_rdata", core_rdata_3, 32'hC0DE_0030);
    chk("t4_c3_dbg_rvalid", dbg_rvalid_3, 0);
    cyc(); idle(); settle();
    chk("t4_c4_dbg_rvalid", dbg_rvalid_3, 1);
    chk("t4_c4_dbg_rdata", dbg_rdata_3, 32'hC0DE_0050);
    chk("t4_c4_core_rvalid", core_rvalid_3, 0);
    chk("t4_c4_core_hold", core_rdata_3, 32'hC0DE_0030);
    cyc(); settle();
    chk("t4_c5_core_rvalid", core_rvalid_3, 1);
    chk("t4_c5_core_rdata", core_rdata_3, 32'hC0DE_0060);
    chk("t4_c5_dbg_rvalid", dbg_rvalid_3, 0);
    cyc(); settle();
    chk("t4_c6_dbg_rvalid", dbg_rvalid_3, 1);
    chk("t4_c6_dbg_rdata", dbg_rdata_3, 32'hC0DE_0070);
    cyc(); settle();
    chk("t4_c7_core_rvalid", core_rvalid_3, 0);
    chk("t4_c7_dbg_rvalid", dbg_rvalid_3, 0);
    cyc();

    // Reset with a core read in flight.
    core_req = 1'b1; core_addr = 32'h10;
    settle();
    chk("t5_core_gnt", core_gnt_3, 1);
    cyc();
    rst_n = 1'b0;
    dbg_lock = 1'b1;
    settle();
    chk("t5_rst_stall", core_stall_3, 0);
    chk("t5_rst_core_gnt", core_gnt_3, 0);
    chk("t5_rst_l1_rvalid", core_rvalid_1, 0);
    chk("t5_rst_l3_rvalid", core_rvalid_3, 0);
    chk("t5_rst_mem_we", mem_we_1, 0);
    chk("t5_rst_mem_addr", mem_addr_1, 0);
    chk("t5_rst_l1_rdata", core_rdata_1, 0);
    chk("t5_rst_l3_rdata", core_rdata_3, 0);
    chk("t5_rst_dbg_rdata", dbg_rdata_3, 0);
    cyc(); idle(); dbg_lock = 1'b0;
    cyc();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk($sformatf("t5_post_l3_rvalid_c%0d", k), core_rvalid_3, 0);
      chk($sformatf("t5_post_l1_rvalid_c%0d", k), core_rvalid_1, 0);
      cyc();
    end
    settle();
    chk("t5_post_rdata", core_rdata_3, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Arbitrates the single unified instruction/data memory between two requesters:
- the multicycle core's memory port (fetch and load/store);
- a debug/program-loader port (UART loader, testbench backdoor).

Sits between the core datapath/control and the memory macro. It issues at most one memory access per cycle, routes read data back to the owner, and stalls the core while the loader holds the memory.

Parameters:
ADDR_W, 32, address width in bits (byte address)
DATA_W, 32, data width in bits; must be 32
READ_LAT, 1, memory read latency in cycles (1..4)
STARVE_MAX, 8, consecutive cycles dbg may wait on core traffic before it is forced a grant (2..255)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
core_req  in  1  core access request, level
core_we  in  1  1=write, 0=read
core_addr  in  ADDR_W  core byte address
core_wdata  in  DATA_W  core write data
core_wmask  in  4  core byte enables
core_gnt  out  1  core access accepted this cycle
core_rvalid  out  1  core read data valid
core_rdata  out  DATA_W  core read data
dbg_req  in  1  debug access request, level
dbg_we  in  1  1=write, 0=read
dbg_addr  in  ADDR_W  debug byte address
dbg_wdata  in  DATA_W  debug write data
dbg_wmask  in  4  debug byte enables
dbg_lock  in  1  debug owns memory exclusively (loader mode)
dbg_gnt  out  1  debug access accepted this cycle
dbg_rvalid  out  1  debug read data valid
dbg_rdata  out  DATA_W  debug read data
mem_addr  out  ADDR_W  memory address, word-aligned (bits [1:0] forced 0)
mem_we  out  1  memory write strobe
mem_wmask  out  4  memory byte enables
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, READ_LAT cycles after address
core_stall  out  1  core must hold its state machine

Behaviour:
- Grant is combinational from current requests and registered state.
  - At most one of core_gnt/dbg_gnt is high per cycle.
  - The mem_* outputs mux the granted requester's signals in the same cycle.
  - With no grant: mem_we=0, mem_wmask=0, mem_addr/mem_wdata=0.
- Priority:
  - dbg_lock=1: only dbg may be granted. core_gnt=0, core_stall=1.
  - Otherwise the core wins a conflict, except when starve_cnt==STARVE_MAX, in which case dbg wins.
- starve_cnt (8-bit):
  - increments on cycles with dbg_req=1 and dbg_gnt=0, saturating at STARVE_MAX;
  - clears on dbg_gnt or dbg_req=0.
- core_stall = core_req & ~core_gnt, or dbg_lock. It is asserted in the same cycle as the lost grant.
- Writes: accepted on gnt; no response. mem_we=1 for exactly the grant cycle.
- Reads: a granted read pushes an owner tag (valid, id) into a READ_LAT-deep shift register.
  - When a tag exits, the owner's rvalid pulses for 1 cycle and its rdata=mem_rdata.
  - The other port's rdata holds its last value.
  - Back-to-back reads every cycle are legal and return in order.
- dbg_lock rising while core reads are in flight: in-flight responses still return to the core.
- dbg_lock falling: the core may be granted in the next cycle.
- Requests need not be held after gnt. A requester without gnt must hold its request stable.
- Reset (rst_n=0, async):
  - tag pipeline cleared, starve_cnt=0, rdata registers=0;
  - all gnt/rvalid=0 and mem_we=0. While reset is asserted, core_stall=0 regardless of dbg_lock.
  - Reads in flight at reset are dropped: no rvalid after release.

Decomposition:
- Package mem_arb_pkg:
  - typedef owner_t (OWN_CORE=1'b0, OWN_DBG=1'b1);
  - struct rd_tag_t {valid, owner_t owner};
  - localparams for the default widths.
- One sub-module, rd_tag_pipe: a parameterised READ_LAT-deep shift register of rd_tag_t with async active-low reset.

Test Plan:
1. Core-only read at 0x0000_0010, mem returns 0xDEADBEEF at READ_LAT=1 -> core_gnt in cycle 0, core_rvalid=1 in cycle 1 with core_rdata=0xDEADBEEF, dbg_rvalid=0.
2. Core and dbg request simultaneously, no lock -> core granted, core_stall=0. After dbg waits 8 cycles with core_req held high, dbg_gnt=1 on the 9th cycle and core_stall=1 that cycle.
3. dbg_lock=1 with dbg writing 0x12345678, mask 0xF, to 0x100 while core_req=1 -> mem_we=1, mem_addr=0x100, core_gnt=0, core_stall=1. Lock released -> core_gnt=1 next cycle.
4. READ_LAT=3, alternating core/dbg reads every cycle -> rvalids arrive in the same order, each exactly 3 cycles after its grant, with matching data.
5. Core read granted, rst_n pulled low mid-flight -> no core_rvalid after release; all outputs 0 during reset.
6. dbg byte write, mask 0b0100, to 0x203 -> mem_addr=0x200, mem_wmask=0b0100, mem_we high for exactly 1 cycle.
